audio_i2s_tx: RTL

Serial DAC transmitter for the audio playback path. It consumes 16-bit mono samples from the sample ROM, whose address is stepped by the audio address generator. It shifts each sample out to the codec DAC in left-justified format on both channels. It drives the `INIT_FINISH` / `data_over` handshake that the address generator waits on. It sits between the sample ROM data port and the board codec pins (`AUD_BCLK`, `AUD_DACLRCK`, `AUD_DACDAT`).

---
 rtl/audio_pkg.sv | 14 +
 rtl/audio_bclk_gen.sv | 42 ++++
 rtl/audio_i2s_tx.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/audio_pkg.sv
// Shared audio playback definitions.
// Imported by the I2S transmitter and the address generator.
package audio_pkg;

  localparam int AUDIO_DATA_W     = 16;
  localparam int AUDIO_FRAME_BITS = 32;

  typedef enum logic [1:0] {
    IDLE,
    SETTLE,
    RUN
  } tx_state_t;

endpackage

// File: rtl/audio_bclk_gen.sv
// I2S bit clock divider.
// Strobes flag the cycle before BCLK toggles.
module audio_bclk_gen #(
  parameter int BCLK_DIV = 16
) (
  input  logic Clk,
  input  logic Reset_n,
  input  logic enable,
  output logic AUD_BCLK,
  output logic bclk_fall,
  output logic bclk_rise
);

  localparam int DW =
    (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST =
    DW'(BCLK_DIV - 1);

  logic [DW-1:0] div_q;
  logic          term;

  assign term      = enable
                   && (div_q == DIV_LAST);
  assign bclk_rise = term && !AUD_BCLK;
  assign bclk_fall = term && AUD_BCLK;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      div_q    <= '0;
      AUD_BCLK <= 1'b0;
    end else if (!enable) begin
      div_q    <= '0;
      AUD_BCLK <= 1'b0;
    end else if (term) begin
      div_q    <= '0;
      AUD_BCLK <= ~AUD_BCLK;
    end else begin
      div_q <= div_q + DW'(1);
    end
  end

endmodule

// File: rtl/audio_i2s_tx.sv
// Left-justified mono I2S DAC transmitter.
// Start/settle FSM plus frame shifter and data_over handshake.
module audio_i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV    = 16,
  parameter int INIT_CYCLES = 1024,
  parameter int OVER_LEN    = 4
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    INIT,
  input  logic [AUDIO_DATA_W-1:0] sample_in,
  output logic                    INIT_FINISH,
  output logic                    data_over,
  output logic                    AUD_BCLK,
  output logic                    AUD_DACLRCK,
  output logic                    AUD_DACDAT
);

  localparam int SW =
    (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
  localparam int OW =
    (OVER_LEN > 1) ? $clog2(OVER_LEN) : 1;
  localparam int BW = $clog2(AUDIO_FRAME_BITS);

  localparam logic [SW-1:0] SETTLE_LAST =
    SW'(INIT_CYCLES - 1);
  localparam logic [OW-1:0] OVER_LAST =
    OW'(OVER_LEN - 1);
  localparam logic [BW-1:0] BIT_LAST =
    BW'(AUDIO_FRAME_BITS - 1);
  localparam logic [BW-1:0] SLOT_LAST =
    BW'(AUDIO_FRAME_BITS / 2 - 1);

  tx_state_t               state_q;
  logic [SW-1:0]           settle_q;
  logic [BW-1:0]           bit_q;
  logic [OW-1:0]           over_q;
  logic [AUDIO_DATA_W-1:0] hold_q;
  logic [AUDIO_DATA_W-1:0] shift_q;
  logic                    run_en;
  logic                    bclk_fall;
  logic                    rise_unused;
  logic                    settle_done;
  logic                    frame_start;

  assign run_en      = (state_q == RUN) && INIT;
  assign settle_done = (state_q == SETTLE)
                     && (settle_q == SETTLE_LAST);
  assign frame_start = INIT
                     && (settle_done
                      || (state_q == RUN
                       && bclk_fall
                       && bit_q == BIT_LAST));
  assign AUD_DACDAT  = shift_q[AUDIO_DATA_W-1];

  audio_bclk_gen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_bclk (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .enable    (run_en),
    .AUD_BCLK  (AUD_BCLK),
    .bclk_fall (bclk_fall),
    .bclk_rise (rise_unused)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= IDLE;
      settle_q    <= '0;
      INIT_FINISH <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          settle_q    <= '0;
          INIT_FINISH <= 1'b0;
          if (INIT) begin
            state_q <= SETTLE;
          end
        end
        SETTLE: begin
          if (!INIT) begin
            state_q  <= IDLE;
            settle_q <= '0;
          end else if (settle_done) begin
            state_q     <= RUN;
            settle_q    <= '0;
            INIT_FINISH <= 1'b1;
          end else begin
            settle_q <= settle_q + SW'(1);
          end
        end
        RUN: begin
          if (!INIT) begin
            state_q     <= IDLE;
            INIT_FINISH <= 1'b0;
          end
        end
        default: begin
          state_q     <= IDLE;
          settle_q    <= '0;
          INIT_FINISH <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      hold_q      <= '0;
      shift_q     <= '0;
      bit_q       <= '0;
      over_q      <= '0;
      data_over   <= 1'b0;
      AUD_DACLRCK <= 1'b0;
    end else if (frame_start) begin
      hold_q      <= sample_in;
      shift_q     <= sample_in;
      bit_q       <= '0;
      over_q      <= '0;
      data_over   <= 1'b1;
      AUD_DACLRCK <= 1'b1;
    end else if (!run_en) begin
      hold_q      <= '0;
      shift_q     <= '0;
      bit_q       <= '0;
      over_q      <= '0;
      data_over   <= 1'b0;
      AUD_DACLRCK <= 1'b0;
    end else begin
      if (data_over) begin
        if (over_q == OVER_LAST) begin
          data_over <= 1'b0;
        end else begin
          over_q <= over_q + OW'(1);
        end
      end
      if (bclk_fall) begin
        bit_q <= bit_q + BW'(1);
        if (bit_q == SLOT_LAST) begin
          shift_q     <= hold_q;
          AUD_DACLRCK <= 1'b0;
        end else begin
          shift_q <= shift_q << 1;
        end
      end
    end
  end

endmodule
